// File: rtl/axi4l_regfile_if.sv
// AXI4-Lite bus bundle shared between the bridge (master) and register banks (slave).
// Latency: none, wires only.
// Backpressure: carried by the per-channel valid/ready pairs.
interface axi4l_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Write address channel
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    // Write data channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    // Write response channel
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // Read address channel
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    // Read data channel
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4l_regfile.sv
// AXI4-Lite slave bank of NUM_REGS byte-writable control registers, exported flat on REGS_OUT.
// Latency: write visible on REGS_OUT 2 cycles after the later of AW/W handshakes; read data 1 cycle after AR.
// Backpressure: one outstanding op per direction; AW/W held off until B accepted, AR held off until R accepted.
// Optional: define AXI4L_REGFILE_WPULSE_EN to add WR_PULSE, a per-register one-cycle write strobe.
module axi4l_regfile #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           CLK,
    input  logic                           RSTN,
    axi4l_if.slave                         AXI4LITE_PORT,
    output logic [NUM_REGS*DATA_WIDTH-1:0] REGS_OUT
`ifdef AXI4L_REGFILE_WPULSE_EN
    ,
    output logic [NUM_REGS-1:0]            WR_PULSE
`endif
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register storage
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Write-side held state: AW and W are captured independently
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    // Read-side state
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Decode and handshake terms
    logic                  awready_c;
    logic                  wready_c;
    logic                  arready_c;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic                  wr_in_range;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_val;

    // Readies come only from flops. Holding awready/wready low until bvalid drops
    // keeps the write path to one outstanding transaction.
    assign awready_c = !aw_held && !bvalid_q;
    assign wready_c  = !w_held  && !bvalid_q;
    assign arready_c = !rvalid_q;

    assign aw_hs = AXI4LITE_PORT.awvalid && awready_c;
    assign w_hs  = AXI4LITE_PORT.wvalid  && wready_c;
    assign b_hs  = bvalid_q && AXI4LITE_PORT.bready;
    assign ar_hs = AXI4LITE_PORT.arvalid && arready_c;
    assign r_hs  = rvalid_q && AXI4LITE_PORT.rready;

    // Commit once both halves are held; bvalid_q guards against a second commit
    // while the response for this one is still waiting.
    assign commit      = aw_held && w_held && !bvalid_q;
    assign wr_idx      = awaddr_q >> ADDR_LSB;
    assign wr_in_range = (wr_idx < NUM_REGS_A);

    assign rd_idx      = AXI4LITE_PORT.araddr >> ADDR_LSB;
    assign rd_in_range = (rd_idx < NUM_REGS_A);

    // Drive the slave-side outputs of the bus
    assign AXI4LITE_PORT.awready = awready_c;
    assign AXI4LITE_PORT.wready  = wready_c;
    assign AXI4LITE_PORT.bvalid  = bvalid_q;
    assign AXI4LITE_PORT.bresp   = bresp_q;
    assign AXI4LITE_PORT.arready = arready_c;
    assign AXI4LITE_PORT.rvalid  = rvalid_q;
    assign AXI4LITE_PORT.rresp   = rresp_q;
    assign AXI4LITE_PORT.rdata   = rdata_q;

    // Capture the write address and hold it until the commit consumes it
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            aw_held  <= 1'b0;
            awaddr_q <= '0;
        end else if (aw_hs) begin
            aw_held  <= 1'b1;
            awaddr_q <= AXI4LITE_PORT.awaddr;
        end else if (commit) begin
            aw_held  <= 1'b0;
        end
    end

    // Capture the write data/strobes and hold them until the commit consumes them
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            w_held  <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= AXI4LITE_PORT.wdata;
            wstrb_q <= AXI4LITE_PORT.wstrb;
        end else if (commit) begin
            w_held  <= 1'b0;
        end
    end

    // Raise the write response after a commit and hold it until accepted
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (b_hs) begin
            bvalid_q <= 1'b0;
        end
    end

    // Byte-lane update of the addressed register; out-of-range commits touch nothing
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else if (commit && wr_in_range) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == ADDR_WIDTH'(i)) begin
                    for (int k = 0; k < STRB_W; k++) begin
                        if (wstrb_q[k]) begin
                            regs[i][8*k +: 8] <= wdata_q[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux over the current register flops; a same-cycle commit is not yet visible here
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == ADDR_WIDTH'(i)) begin
                rd_val = regs[i];
            end
        end
    end

    // Register read data on AR and hold it stable until R is accepted
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata_q  <= rd_in_range ? rd_val : '0;
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
        end
    end

    // Flatten the register array onto the datapath export
    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_regs_out
            assign REGS_OUT[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
        end
    endgenerate

`ifdef AXI4L_REGFILE_WPULSE_EN
    // One-cycle strobe per in-range commit, landing with the new value on REGS_OUT
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            WR_PULSE <= '0;
        end else begin
            WR_PULSE <= '0;
            if (commit && wr_in_range) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_idx == ADDR_WIDTH'(i)) begin
                        WR_PULSE[i] <= 1'b1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi4l_regfile.sv
// Directed bench for axi4l_regfile: vector table of single transactions plus
// hand-written multi-cycle sequences (latency, backpressure, W-before-AW,
// read/commit collision, reset while a response is pending).
module tb_axi4l_regfile;

    logic         CLK;
    logic         RSTN;
    logic [511:0] regs_out;
`ifdef AXI4L_REGFILE_WPULSE_EN
    logic [15:0]  wr_pulse;
`endif

    axi4l_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4l_regfile #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .NUM_REGS    (16),
        .RESET_VALUE (32'h0)
    ) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .AXI4LITE_PORT (bus.slave),
        .REGS_OUT      (regs_out)
`ifdef AXI4L_REGFILE_WPULSE_EN
        ,
        .WR_PULSE      (wr_pulse)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] shadow [16];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] exp;
        int          idx;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout waiting on DUT", name);
    endtask

    function automatic logic [31:0] reg_at(input int i);
        return regs_out[i*32 +: 32];
    endfunction

    task automatic check_regs(input string name);
        logic [511:0] expv;
        for (int i = 0; i < 16; i++) expv[i*32 +: 32] = shadow[i];
        n_cmp++;
        if (regs_out !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, regs_out, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        int  n;
        logic aw_go, w_go;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        n = 0;
        while ((bus.awvalid || bus.wvalid) && n < 20) begin
            aw_go = bus.awvalid && bus.awready;
            w_go  = bus.wvalid  && bus.wready;
            tick();
            if (aw_go) bus.awvalid = 1'b0;
            if (w_go)  bus.wvalid  = 1'b0;
            n++;
        end
        resp = 2'bxx;
        if (bus.awvalid || bus.wvalid) begin
            timeout("write addr/data accept");
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
        end else begin
            n = 0;
            while (!bus.bvalid && n < 20) begin
                tick();
                n++;
            end
            if (!bus.bvalid) begin
                timeout("write response");
            end else begin
                resp = bus.bresp;
                tick();
            end
        end
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        n = 0;
        while (!bus.arready && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus.arvalid = 1'b0;
        data = 32'hx;
        resp = 2'bxx;
        n = 0;
        while (!bus.rvalid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.rvalid) begin
            timeout("read data");
        end else begin
            data = bus.rdata;
            resp = bus.rresp;
            tick();
        end
        bus.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int          nb;

        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'hDEAD_BEEF, 2};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 2};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'h1122_3344, 4'hF, 2'b00, 32'h1122_3344, 1};
        vecs[3]  = '{1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h11BB_33DD, 1};
        vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD, 1};
        vecs[5]  = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 2'b10, 32'h0,        -1};
        vecs[6]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 2'b10, 32'h0,        -1};
        vecs[7]  = '{1'b0, 32'h0000_000B, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 2};
        vecs[8]  = '{1'b1, 32'h0000_003C, 32'hFFFF_FFFF, 4'hC, 2'b00, 32'hFFFF_0000, 15};
        vecs[9]  = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 2'b00, 32'hFFFF_0000, 15};
        vecs[10] = '{1'b1, 32'h0000_0000, 32'h0000_0055, 4'h0, 2'b00, 32'h0,         0};
        vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0,        -1};
        vecs[12] = '{1'b1, 32'h0000_003E, 32'h0000_ABCD, 4'h3, 2'b00, 32'hFFFF_ABCD, 15};
        vecs[13] = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 2'b00, 32'hFFFF_ABCD, 15};

        for (int i = 0; i < 16; i++) shadow[i] = 32'h0;

        RSTN        = 1'b0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        repeat (3) tick();
        RSTN = 1'b1;

        // Reset state
        check("rst awready", bus.awready, 1);
        check("rst wready",  bus.wready,  1);
        check("rst arready", bus.arready, 1);
        check("rst bvalid",  bus.bvalid,  0);
        check("rst rvalid",  bus.rvalid,  0);
        check("rst bresp",   bus.bresp,   0);
        check("rst rresp",   bus.rresp,   0);
        check("rst rdata",   bus.rdata,   0);
        check_regs("rst regs");

        // Vector table
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                check($sformatf("vec%0d bresp", i), resp, vecs[i].resp);
                if (vecs[i].idx >= 0) shadow[vecs[i].idx] = vecs[i].exp;
                check_regs($sformatf("vec%0d regs", i));
            end else begin
                do_read(vecs[i].addr, rd, resp);
                check($sformatf("vec%0d rresp", i), resp, vecs[i].resp);
                check($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
            end
        end

        // Write latency, then B backpressure with a second write waiting
        bus.awaddr = 32'h10; bus.wdata = 32'h0000_A5A5; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("lat T+1 reg4 old", reg_at(4), 32'h0);
        check("lat T+1 bvalid",   bus.bvalid, 0);
        tick();
        check("lat T+2 reg4 new", reg_at(4), 32'h0000_A5A5);
        check("lat T+2 bvalid",   bus.bvalid, 1);
        shadow[4] = 32'h0000_A5A5;
        bus.awaddr = 32'h14; bus.wdata = 32'h0000_0077; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d bvalid",  c), bus.bvalid,  1);
            check($sformatf("bp%0d bresp",   c), bus.bresp,   2'b00);
            check($sformatf("bp%0d awready", c), bus.awready, 0);
            check($sformatf("bp%0d wready",  c), bus.wready,  0);
            tick();
        end
        check("bp reg5 untouched", reg_at(5), 32'h0);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("bp after B bvalid",  bus.bvalid,  0);
        check("bp after B awready", bus.awready, 1);
        check("bp after B wready",  bus.wready,  1);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        nb = 0;
        while (!bus.bvalid && nb < 20) begin tick(); nb++; end
        if (!bus.bvalid) timeout("second write response");
        else check("bp second bresp", bus.bresp, 2'b00);
        tick();
        bus.bready = 1'b0;
        shadow[5] = 32'h0000_0077;
        check_regs("bp regs");

        // W three cycles ahead of AW
        do_write(32'h4, 32'h1122_3344, 4'hF, resp);
        shadow[1] = 32'h1122_3344;
        bus.wdata = 32'hAABB_CCDD; bus.wstrb = 4'h5; bus.wvalid = 1'b1; bus.bready = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        check("wfirst wready low", bus.wready, 0);
        repeat (2) tick();
        check("wfirst no early B", bus.bvalid, 0);
        bus.awaddr = 32'h4; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        nb = 0;
        resp = 2'bxx;
        repeat (8) begin
            if (bus.bvalid) begin nb++; resp = bus.bresp; end
            tick();
        end
        bus.bready = 1'b0;
        check("wfirst B count", nb, 1);
        check("wfirst bresp", resp, 2'b00);
        shadow[1] = 32'h11BB_33DD;
        check_regs("wfirst regs");

        // R backpressure
        bus.araddr = 32'h8; bus.arvalid = 1'b1; bus.rready = 1'b0;
        tick();
        bus.arvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rbp%0d rvalid",  c), bus.rvalid,  1);
            check($sformatf("rbp%0d rdata",   c), bus.rdata,   32'hDEAD_BEEF);
            check($sformatf("rbp%0d arready", c), bus.arready, 0);
            tick();
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("rbp after R rvalid",  bus.rvalid,  0);
        check("rbp after R arready", bus.arready, 1);

        // Read captured in the commit cycle of a write to the same register
        bus.awaddr = 32'hC; bus.wdata = 32'h5; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 32'hC; bus.arvalid = 1'b1; bus.rready = 1'b1; bus.bready = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check("coll rvalid", bus.rvalid, 1);
        check("coll rdata old", bus.rdata, 32'h0);
        check("coll bvalid", bus.bvalid, 1);
        tick();
        bus.rready = 1'b0; bus.bready = 1'b0;
        do_read(32'hC, rd, resp);
        check("coll later rdata new", rd, 32'h5);
        shadow[3] = 32'h5;

`ifdef AXI4L_REGFILE_WPULSE_EN
        // Write strobe alignment
        bus.awaddr = 32'h8; bus.wdata = 32'h1; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("wp T+1", wr_pulse, 16'h0000);
        tick();
        check("wp T+2", wr_pulse, 16'h0004);
        check("wp T+2 reg2", reg_at(2), 32'h1);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("wp T+3", wr_pulse, 16'h0000);
        shadow[2] = 32'h1;
        bus.awaddr = 32'h40; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        tick();
        check("wp oor T+2", wr_pulse, 16'h0000);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("wp oor T+3", wr_pulse, 16'h0000);
`endif

        // Reset while a write response is pending
        bus.awaddr = 32'h18; bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        nb = 0;
        while (!bus.bvalid && nb < 20) begin tick(); nb++; end
        if (!bus.bvalid) timeout("pre-reset response");
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
        check("mrst bvalid", bus.bvalid, 0);
        check("mrst awready", bus.awready, 1);
        check_regs("mrst regs");
        bus.bready = 1'b1;
        nb = 0;
        repeat (6) begin
            if (bus.bvalid) nb++;
            tick();
        end
        bus.bready = 1'b0;
        check("mrst no stale B", nb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi4l_regfile.md
Name: axi4l_regfile

Overview:
- AXI4-Lite slave register bank. It sits directly downstream of the Wishbone-to-AXI4-Lite bridge and terminates its AXI4LITE_PORT.
- Provides NUM_REGS read/write control registers, exported as a flat vector to the datapath.
- Byte-lane writes, SLVERR on out-of-range addresses.
- Single outstanding transaction per direction; the read and write paths are independent.

Parameters:
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 32: AXI data and register width; legal values are 32 or 64.
- NUM_REGS, 16: number of registers, 1..256.
- RESET_VALUE, 0: reset value of every register, DATA_WIDTH bits.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  synchronous active-low reset.
- AXI4LITE_PORT  axi4l_if.slave  -  members used: awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready.
- REGS_OUT  out  NUM_REGS*DATA_WIDTH  register contents; register i is at bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset: RSTN is synchronous and active-low; clock is CLK. Reset drives:
  - awready=1, wready=1, arready=1
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0
  - all registers = RESET_VALUE
  - any held AW/W state cleared.
- Reset mid-transaction: the transaction is dropped and no response is issued.
- Address decode:
  - ADDR_LSB = log2(DATA_WIDTH/8); index = addr >> ADDR_LSB.
  - The low ADDR_LSB bits are ignored.
  - index >= NUM_REGS is out of range.
- Write path, AW and W captured independently:
  - AW handshake (awvalid&awready): latch awaddr, set aw_held, awready=0 next cycle.
  - W handshake: latch wdata/wstrb, set w_held, wready=0 next cycle.
  - AW and W may arrive in the same cycle or in either order, with any gap between them.
- Write commit happens in the cycle where aw_held and w_held are both set (registered view) and bvalid=0:
  - In range: each byte lane k with wstrb[k]=1 is updated; other lanes are kept. bresp=2'b00 (OKAY).
  - Out of range: no register changes. bresp=2'b10 (SLVERR).
  - The next cycle: bvalid=1, aw_held=0, w_held=0.
  - Write latency: the commit is visible on REGS_OUT 2 cycles after the later of the AW/W handshakes.
- B channel:
  - bvalid is held with bresp stable until bready.
  - awready and wready return to 1 in the cycle after the B handshake, not before.
  - A new AW/W can be accepted in the cycle after the B handshake.
- Read path:
  - arready=1 whenever rvalid=0 and no read is pending.
  - AR handshake: rvalid=1 the next cycle. In range: rdata=register, rresp=2'b00. Out of range: rdata=0, rresp=2'b10.
  - rdata and rresp are held stable until rready; arready is low while rvalid=1.
  - arready=1 the cycle after the R handshake. Throughput is 1 read per 2 cycles.
- Read/write interaction:
  - A read captured in the same cycle as a write commit to the same register returns the pre-write value.
  - A read captured in any later cycle returns the new value.
- Backpressure: bready=0 or rready=0 for any number of cycles loses nothing; the other channel continues independently.
- REGS_OUT is driven directly from the register flops; it has no combinational path from AXI inputs.

Optional Feature:
- Macro: AXI4L_REGFILE_WPULSE_EN.
- When defined, add port WR_PULSE  out  NUM_REGS:
  - Bit i is high for exactly one cycle, aligned with the cycle REGS_OUT first shows the new value, for each in-range write commit to register i.
  - This includes a write with wstrb=0.
  - Resets to 0. Out-of-range writes pulse nothing.
- When undefined: the port does not exist and there is no extra logic.

Test Plan:
- Write 0xDEADBEEF to addr 0x08, wstrb=0xF, AW and W in the same cycle -> bvalid with bresp=00; REGS_OUT[2] reads 0xDEADBEEF; read of 0x08 returns rdata=0xDEADBEEF, rresp=00.
- Partial write:
  - REG1 = 0x11223344; write 0xAABBCCDD to 0x04 with wstrb=0x5 -> REG1 = 0x11BB33DD.
  - Same write with W given 3 cycles before AW -> same result, single B response.
- Out of range, NUM_REGS=16:
  - Write to 0x40 -> bresp=10 and every register unchanged.
  - Read 0x40 -> rdata=0, rresp=10.
- Backpressure:
  - Hold bready=0 for 5 cycles after a write -> bvalid and bresp stable; awready=wready=0 throughout; a second write is accepted only after the B handshake.
  - Hold rready=0 for 4 cycles -> rdata stable, arready=0.
- Collision and reset:
  - Read and commit to 0x0C in the same cycle (old=0x0, new=0x5) -> read returns 0x0; a following read returns 0x5.
  - Assert RSTN=0 while bvalid=1 -> bvalid=0, registers = RESET_VALUE, no stale response after reset.
- With AXI4L_REGFILE_WPULSE_EN: write to 0x08 -> WR_PULSE=0x0004 for one cycle; an out-of-range write -> WR_PULSE stays 0.
